sync_fifo_prog: RTL and testbench

//  Next-generation single-clock FIFO for datapath buffering between same-clock producer/consumer.

---
 rtl/sync_fifo_prog.sv | 109 ++++++++++
 tb/tb_sync_fifo_prog.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, a peak-occupancy watermark and an
// explicit output-valid. LOOKAHEAD selects registered read (0) or
// first-word-fall-through (1).
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int LOOKAHEAD  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   afull_lvl,
  input  logic [ADDR_WIDTH:0]   aempty_lvl,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   uw,
  output logic [ADDR_WIDTH:0]   peak_uw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int UW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  clr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [ADDR_WIDTH:0]   uw_nxt;

  // Accept decisions and next occupancy; clears suppress both ports.
  always_comb begin
    clr    = rst || sclr;
    wr_acc = wr_en && !full && !clr;
    rd_acc = rd_en && !empty && !clr;
    uw_nxt = clr ? '0 : (uw + UW'(wr_acc) - UW'(rd_acc));
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy, registered flags, watermark and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      uw        <= '0;
      peak_uw   <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sclr)        wr_ptr <= '0;
      else if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (sclr)        rd_ptr <= '0;
      else if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      uw     <= uw_nxt;
      empty  <= (uw_nxt == '0);
      full   <= (uw_nxt == UW'(DEPTH));
      afull  <= (uw_nxt >= afull_lvl);
      aempty <= (uw_nxt <= aempty_lvl);
      if (sclr)                  peak_uw <= '0;
      else if (uw_nxt > peak_uw) peak_uw <= uw_nxt;
      // A new error wins over a same-edge clear; sclr leaves flags alone.
      overflow  <= (overflow  && !err_clr) || (wr_en && full  && !sclr);
      underflow <= (underflow && !err_clr) || (rd_en && empty && !sclr);
    end
  end

  generate
    if (LOOKAHEAD != 0) begin : g_fwft
      // Head word is always presented; valid whenever something is stored.
      always_comb begin
        data_out   = mem[rd_ptr];
        data_valid = !empty;
      end
    end else begin : g_reg
      // Registered read: one-cycle latency, output holds between reads.
      always_ff @(posedge clk) begin
        if (rst || sclr) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else if (rd_acc) begin
          data_out   <= mem[rd_ptr];
          data_valid <= 1'b1;
        end else begin
          data_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read instance and a
// lookahead instance driven from one linear sequence.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst, sclr, wr_en, rd_en, err_clr;
  logic [31:0] data_in;
  logic [8:0]  afull_lvl, aempty_lvl;
  logic [31:0] data_out;
  logic        data_valid, empty, full, afull, aempty, overflow, underflow;
  logic [8:0]  uw, peak_uw;

  logic        rst_1, sclr_1, wr_en_1, rd_en_1;
  logic [31:0] data_in_1;
  logic [31:0] data_out_1;
  logic        data_valid_1, empty_1, full_1, afull_1, aempty_1, overflow_1, underflow_1;
  logic [8:0]  uw_1, peak_uw_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LOOKAHEAD(0)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
    .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .empty(empty), .full(full),
    .afull(afull), .aempty(aempty), .uw(uw), .peak_uw(peak_uw),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_prog #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LOOKAHEAD(1)) dut_la (
    .clk(clk), .rst(rst_1), .sclr(sclr_1), .data_in(data_in_1), .wr_en(wr_en_1), .rd_en(rd_en_1),
    .afull_lvl(afull_lvl), .aempty_lvl(aempty_lvl), .err_clr(err_clr),
    .data_out(data_out_1), .data_valid(data_valid_1), .empty(empty_1), .full(full_1),
    .afull(afull_1), .aempty(aempty_1), .uw(uw_1), .peak_uw(peak_uw_1),
    .overflow(overflow_1), .underflow(underflow_1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; sclr = 0; wr_en = 0; rd_en = 0; err_clr = 0; data_in = 0;
    afull_lvl = 9'd248; aempty_lvl = 9'd8;
    rst_1 = 1; sclr_1 = 0; wr_en_1 = 0; rd_en_1 = 0; data_in_1 = 0;

    // reset state
    tick;
    check("rst_uw", uw, 0);
    check("rst_peak", peak_uw, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_aempty", aempty, 1);
    check("rst_dout", data_out, 0);
    check("rst_dvalid", data_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst = 0;

    // write 1..16
    for (int i = 1; i <= 16; i++) begin
      data_in = i; wr_en = 1;
      tick;
      check("w16_empty", empty, 0);
      check("w16_aempty", aempty, (i <= 8));
    end
    check("w16_uw", uw, 16);
    check("w16_peak", peak_uw, 16);

    // fill to 256
    for (int i = 17; i <= 256; i++) begin
      data_in = i;
      tick;
      check("fill_afull", afull, (i >= 248));
      check("fill_full", full, (i == 256));
    end
    check("fill_uw", uw, 256);
    check("fill_peak", peak_uw, 256);
    data_in = 32'hDEAD;
    tick;
    check("ovf_set", overflow, 1);
    check("ovf_uw", uw, 256);
    wr_en = 0; err_clr = 1;
    tick;
    check("ovf_clr", overflow, 0);
    err_clr = 0;

    // drain: contents must be 1..256, the rejected write must not appear
    rd_en = 1;
    for (int i = 1; i <= 256; i++) begin
      tick;
      check("drain_data", data_out, i);
      check("drain_valid", data_valid, 1);
    end
    check("drain_empty", empty, 1);
    tick;
    check("drain_unf", underflow, 1);
    check("drain_hold", data_out, 256);
    rd_en = 0;

    // registered read latency, underflow, err_clr vs new error
    rst = 1; tick; rst = 0;
    check("t3_unf_rst", underflow, 0);
    wr_en = 1;
    for (int i = 1; i <= 3; i++) begin
      data_in = i; tick;
    end
    wr_en = 0; rd_en = 1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("t3_data", data_out, i);
      check("t3_valid", data_valid, 1);
    end
    tick;
    check("t3_unf", underflow, 1);
    check("t3_valid_lo", data_valid, 0);
    check("t3_hold", data_out, 3);
    err_clr = 1;
    tick;
    check("t3_clr_vs_err", underflow, 1);
    rd_en = 0;
    tick;
    check("t3_clr", underflow, 0);
    err_clr = 0;

    // steady-state simultaneous write/read with pointer wrap
    wr_en = 1;
    for (int k = 0; k < 5; k++) begin
      data_in = 32'h1000 + k; tick;
    end
    rd_en = 1;
    for (int j = 0; j < 300; j++) begin
      data_in = 32'h1005 + j;
      tick;
      check("t4_data", data_out, 32'h1000 + j);
      check("t4_uw", uw, 5);
    end
    check("t4_peak", peak_uw, 5);
    rd_en = 0;

    // fill, threshold above depth, overflow, then sclr
    for (int k = 0; k < 251; k++) begin
      data_in = k; tick;
    end
    wr_en = 0;
    check("t5_full", full, 1);
    afull_lvl = 9'd257;
    tick;
    check("t5_afull_gt_depth", afull, 0);
    afull_lvl = 9'd248;
    tick;
    check("t5_afull_back", afull, 1);
    wr_en = 1;
    tick;
    check("t5_ovf", overflow, 1);
    sclr = 1;
    tick;
    check("sclr_uw", uw, 0);
    check("sclr_empty", empty, 1);
    check("sclr_full", full, 0);
    check("sclr_afull", afull, 0);
    check("sclr_aempty", aempty, 1);
    check("sclr_peak", peak_uw, 0);
    check("sclr_ovf", overflow, 1);
    check("sclr_dout", data_out, 0);
    check("sclr_dvalid", data_valid, 0);
    sclr = 0; wr_en = 0; err_clr = 1;
    tick;
    check("t5_ovf_clr", overflow, 0);
    err_clr = 0;

    // threshold changes take effect next edge
    wr_en = 1;
    for (int k = 0; k < 5; k++) begin
      data_in = k; tick;
    end
    wr_en = 0;
    check("thr_uw", uw, 5);
    check("thr_afull0", afull, 0);
    afull_lvl = 9'd4;
    tick;
    check("thr_afull1", afull, 1);
    afull_lvl = 9'd5;
    tick;
    check("thr_afull_eq", afull, 1);
    afull_lvl = 9'd248;
    aempty_lvl = 9'd5;
    tick;
    check("thr_afull_restore", afull, 0);
    check("thr_aempty_eq", aempty, 1);
    aempty_lvl = 9'd4;
    tick;
    check("thr_aempty_below", aempty, 0);
    aempty_lvl = 9'd8;

    // lookahead instance
    rst_1 = 0;
    tick;
    check("la_rst_empty", empty_1, 1);
    check("la_rst_valid", data_valid_1, 0);
    data_in_1 = 32'hA5; wr_en_1 = 1;
    tick;
    wr_en_1 = 0;
    check("la_head", data_out_1, 32'hA5);
    check("la_valid", data_valid_1, 1);
    tick;
    check("la_head_hold", data_out_1, 32'hA5);
    check("la_uw1", uw_1, 1);
    rd_en_1 = 1;
    tick;
    rd_en_1 = 0;
    check("la_pop_empty", empty_1, 1);
    check("la_pop_valid", data_valid_1, 0);
    wr_en_1 = 1;
    data_in_1 = 32'hB1; tick;
    data_in_1 = 32'hB2; tick;
    wr_en_1 = 0;
    check("la_head_b1", data_out_1, 32'hB1);
    rd_en_1 = 1;
    tick;
    rd_en_1 = 0;
    check("la_head_b2", data_out_1, 32'hB2);
    check("la_valid_b2", data_valid_1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
